// File: rtl/lp_tpg_pkg.sv
// lp_tpg_pkg: shared types, constants and next-step functions for the low-power TPG checker.
package lp_tpg_pkg;
  localparam logic [7:0] SEED_DEFAULT = 8'h4B;
  localparam logic [15:0] NUM_VECTORS = 16'd1024;
  localparam logic [7:0] MISR_POLY = 8'h1D;
  localparam logic [7:0] SIG_INIT = 8'h00;
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef struct packed {
    logic [7:0] s;
    logic       t;
    logic [7:0] exp_vec;
  } step_t;
  // Half-shift pattern step: upper nibble shifts in P0, lower in P2; P1/P3 emit intermediate vectors.
  function automatic step_t lp_tpg_next(input logic [7:0] s, input logic t, input phase_e ph);
    step_t o;
    logic [7:0] a, b, r;
    a = {s[7], s[7], s[6], s[4], s[3], s[2], s[1], s[0]};
    b = {s[0] ^ s[7], s[6], s[5], s[5], t, s[3], s[2], s[1]};
    r = s[0] ? (a | b) : (a & b);
    o.t = (ph == PH0) ? s[4] : t;
    o.s = (ph == PH0) ? {s[7] ^ s[0], s[7:5], s[3:0]} :
          (ph == PH2) ? {s[7:4], t, s[3:1]} : s;
    o.exp_vec = (ph == PH1) ? {s[7:4], r[3:0]} :
                (ph == PH3) ? {r[7:4], s[3:0]} : o.s;
    return o;
  endfunction
  function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic [7:0] pat,
                                           input logic [7:0] poly);
    return {sig[6:0], 1'b0} ^ (sig[7] ? poly : 8'h00) ^ pat;
  endfunction
endpackage

// File: rtl/lp_tpg_model.sv
// lp_tpg_model: expected-pattern model holding S, saved bit t and phase; also usable as a golden generator.
module lp_tpg_model import lp_tpg_pkg::*; #(
  parameter logic [7:0] SEED_INIT = 8'h4B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       init_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic [7:0] exp_vec_o,
  output logic [1:0] phase_o
);
  logic [7:0] s_q, seed_q;
  logic       t_q;
  phase_e     ph_q;
  step_t      nxt;
  assign nxt = lp_tpg_next(s_q, t_q, ph_q);
  assign exp_vec_o = nxt.exp_vec;
  assign phase_o = ph_q;
  // A load in the same cycle as init takes the new seed; init alone restarts from the last loaded seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= SEED_INIT;
      seed_q <= SEED_INIT;
      t_q    <= 1'b0;
      ph_q   <= PH0;
    end else begin
      if (load_i) seed_q <= seed_i;
      if (load_i || init_i) begin
        s_q  <= load_i ? seed_i : seed_q;
        t_q  <= 1'b0;
        ph_q <= PH0;
      end else if (step_i) begin
        s_q  <= nxt.s;
        t_q  <= nxt.t;
        ph_q <= phase_e'(ph_q + 2'd1);
      end
    end
  end
endmodule

// File: rtl/lp_tpg_checker.sv
// lp_tpg_checker: checks a received low-power LFSR pattern stream against the seeded model,
// counting mismatches and compacting the stream into a MISR signature.
module lp_tpg_checker #(
  parameter logic [7:0]  SEED_DEFAULT = lp_tpg_pkg::SEED_DEFAULT,
  parameter logic [15:0] NUM_VECTORS  = lp_tpg_pkg::NUM_VECTORS,
  parameter logic [7:0]  MISR_POLY    = lp_tpg_pkg::MISR_POLY,
  parameter logic [7:0]  SIG_INIT     = lp_tpg_pkg::SIG_INIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load_i,
  input  logic [7:0] seed_i,
  input  logic       start_i,
  input  logic       pat_valid_i,
  input  logic [7:0] pat_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       mismatch_o,
  output logic [7:0] err_count_o,
  output logic [7:0] signature_o,
  output logic [1:0] phase_o
);
  import lp_tpg_pkg::*;
  state_e      state_q;
  logic [15:0] cnt_q;
  logic        busy_q, done_q, mismatch_q;
  logic [7:0]  err_q, sig_q, exp_vec;
  logic        run, load, beat, miss, last;
  assign run  = state_q == RUN;
  assign load = seed_load_i && !run;
  assign beat = run && pat_valid_i && !start_i;
  assign miss = pat_i != exp_vec;
  assign last = cnt_q == NUM_VECTORS - 16'd1;
  lp_tpg_model #(.SEED_INIT(SEED_DEFAULT)) u_model (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .init_i    (start_i),
    .step_i    (beat),
    .seed_i    (seed_i),
    .exp_vec_o (exp_vec),
    .phase_o   (phase_o)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      sig_q      <= SIG_INIT;
    end else if (start_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      sig_q      <= SIG_INIT;
    end else begin
      mismatch_q <= beat && miss;
      if (beat) begin
        cnt_q <= cnt_q + 16'd1;
        sig_q <= misr_next(sig_q, pat_i, MISR_POLY);
        if (miss && err_q != 8'hFF) err_q <= err_q + 8'd1;
        if (last) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mismatch_o  = mismatch_q;
  assign err_count_o = err_q;
  assign signature_o = sig_q;
endmodule

// File: tb/tb_lp_tpg_checker.sv
// tb_lp_tpg_checker: table vectors, corner sequences and random stream against a behavioural model.
module tb_lp_tpg_checker;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       seed_load = 1'b0, start = 1'b0, pat_valid = 1'b0;
  logic [7:0] seed = 8'h00, pat_in = 8'h00;
  logic [1:0] busy, done, mm;
  logic [7:0] err [2];
  logic [7:0] sig [2];
  logic [1:0] ph [2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lp_tpg_checker dut_a (
    .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load), .seed_i(seed), .start_i(start),
    .pat_valid_i(pat_valid), .pat_i(pat_in), .busy_o(busy[0]), .done_o(done[0]),
    .mismatch_o(mm[0]), .err_count_o(err[0]), .signature_o(sig[0]), .phase_o(ph[0]));
  lp_tpg_checker #(.NUM_VECTORS(16'd4)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load), .seed_i(seed), .start_i(start),
    .pat_valid_i(pat_valid), .pat_i(pat_in), .busy_o(busy[1]), .done_o(done[1]),
    .mismatch_o(mm[1]), .err_count_o(err[1]), .signature_o(sig[1]), .phase_o(ph[1]));

  // Behavioural model state, one set per DUT
  int         n_vec [2] = '{1024, 4};
  logic [7:0] m_s [2];
  logic [7:0] m_seed [2];
  logic       m_t [2];
  int         m_ph [2], m_cnt [2], m_err [2], m_sig [2];
  logic       m_run [2], m_done [2], m_mm [2];

  function automatic logic bop(input logic use_or, input logic a, input logic b);
    return use_or ? (a | b) : (a & b);
  endfunction

  function automatic void ref_expect(input logic [7:0] s, input logic t, input int p,
                                     output logic [7:0] e, output logic [7:0] s2, output logic t2);
    logic o;
    logic [3:0] hi, lo;
    o  = s[0];
    s2 = s;
    t2 = t;
    hi = {bop(o, s[7], s[0] ^ s[7]), bop(o, s[7], s[6]), bop(o, s[6], s[5]), bop(o, s[4], s[5])};
    lo = {bop(o, s[3], t), bop(o, s[2], s[3]), bop(o, s[1], s[2]), bop(o, s[0], s[1])};
    if (p == 0) begin
      t2 = s[4];
      s2 = 8'((((s >> 7) ^ s) & 8'h01) << 7) | ((s >> 1) & 8'h70) | (s & 8'h0F);
      e  = s2;
    end else if (p == 1) e = {s[7:4], lo};
    else if (p == 2) begin
      s2 = (s & 8'hF0) | 8'({7'd0, t} << 3) | ((s & 8'h0F) >> 1);
      e  = s2;
    end else e = {hi, s[3:0]};
  endfunction

  function automatic int misr(input int s, input int p);
    return (((s << 1) & 255) ^ ((s >= 128) ? 'h1D : 0) ^ p) & 255;
  endfunction

  function automatic logic [7:0] peek_a();
    logic [7:0] e, s2;
    logic t2;
    ref_expect(m_s[0], m_t[0], m_ph[0], e, s2, t2);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s[k] = 8'h4B; m_seed[k] = 8'h4B; m_t[k] = 0; m_ph[k] = 0; m_cnt[k] = 0;
      m_err[k] = 0; m_sig[k] = 0; m_run[k] = 0; m_done[k] = 0; m_mm[k] = 0;
    end
  endtask

  task automatic model_tick(input logic st, input logic sl, input logic [7:0] sd,
                            input logic v, input logic [7:0] p);
    logic [7:0] e, s2;
    logic t2;
    for (int k = 0; k < 2; k++) begin
      m_mm[k] = 0;
      if (sl && !m_run[k]) begin
        m_seed[k] = sd; m_s[k] = sd; m_t[k] = 0; m_ph[k] = 0;
      end
      if (st) begin
        m_s[k] = m_seed[k]; m_t[k] = 0; m_ph[k] = 0; m_run[k] = 1; m_done[k] = 0;
        m_cnt[k] = 0; m_err[k] = 0; m_sig[k] = 0;
      end else if (v && m_run[k]) begin
        ref_expect(m_s[k], m_t[k], m_ph[k], e, s2, t2);
        m_s[k] = s2; m_t[k] = t2; m_ph[k] = (m_ph[k] + 1) % 4;
        m_mm[k] = p != e;
        if (m_mm[k] && m_err[k] != 255) m_err[k]++;
        m_sig[k] = misr(m_sig[k], int'(p));
        m_cnt[k]++;
        if (m_cnt[k] == n_vec[k]) begin m_run[k] = 0; m_done[k] = 1; end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), int'(busy[k]), int'(m_run[k]));
      chk($sformatf("done%0d", k), int'(done[k]), int'(m_done[k]));
      chk($sformatf("mismatch%0d", k), int'(mm[k]), int'(m_mm[k]));
      chk($sformatf("err_count%0d", k), int'(err[k]), m_err[k]);
      chk($sformatf("signature%0d", k), int'(sig[k]), m_sig[k]);
      chk($sformatf("phase%0d", k), int'(ph[k]), m_ph[k]);
    end
  endtask

  task automatic step(input logic st, input logic sl, input logic [7:0] sd,
                      input logic v, input logic [7:0] p);
    start = st; seed_load = sl; seed = sd; pat_valid = v; pat_in = p;
    model_tick(st, sl, sd, v, p);
    @(posedge clk);
    #1;
    compare_all();
    start = 0; seed_load = 0; pat_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    compare_all();
    chk("rst_sig_const", int'(sig[0]), 0);
    chk("rst_busy_const", int'(busy[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct packed {
    logic       st;
    logic       v;
    logic [7:0] pat;
    logic       mm;
    logic [7:0] err;
    logic [1:0] ph;
    logic [7:0] sig;
    logic       done_b;
  } vec_t;
  vec_t tbl [20];

  initial begin
    logic [7:0] e;
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hAB, 1'b0, 8'd0, 2'd1, 8'hAB, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hAF, 1'b0, 8'd0, 2'd2, 8'hE4, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'd0, 2'd3, 8'h70, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'hF5, 1'b0, 8'd0, 2'd0, 8'h15, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h55, 1'b0, 8'd0, 2'd1, 8'h7F, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 2'd0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'hAB, 1'b0, 8'd0, 2'd1, 8'hAB, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hAF, 1'b0, 8'd0, 2'd2, 8'hE4, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'd0, 2'd2, 8'hE4, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 2'd2, 8'hE4, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'hFF, 1'b0, 8'd0, 2'd2, 8'hE4, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'd0, 2'd3, 8'h70, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'hF5, 1'b0, 8'd0, 2'd0, 8'h15, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 8'h55, 1'b0, 8'd0, 2'd1, 8'h7F, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 2'd0, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 8'hAB, 1'b0, 8'd0, 2'd1, 8'hAB, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 8'hAE, 1'b1, 8'd1, 2'd2, 8'hE5, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'd1, 2'd3, 8'h72, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 8'hF5, 1'b0, 8'd1, 2'd0, 8'h11, 1'b1};
    model_reset();
    do_reset();
    // Clean stream, stalled stream, single corrupted beat; dut_b finishes every 4 beats
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].st, 1'b0, 8'h00, tbl[i].v, tbl[i].pat);
      chk($sformatf("tbl%0d_mismatch", i), int'(mm[0]), int'(tbl[i].mm));
      chk($sformatf("tbl%0d_err", i), int'(err[0]), int'(tbl[i].err));
      chk($sformatf("tbl%0d_phase", i), int'(ph[0]), int'(tbl[i].ph));
      chk($sformatf("tbl%0d_sig", i), int'(sig[0]), int'(tbl[i].sig));
      chk($sformatf("tbl%0d_done_b", i), int'(done[1]), int'(tbl[i].done_b));
      chk($sformatf("tbl%0d_busy_b", i), int'(busy[1]), int'(!tbl[i].done_b));
    end
    // Error counter saturation
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      e = peek_a();
      step(1'b0, 1'b0, 8'h00, 1'b1, ~e);
    end
    chk("err_saturate", int'(err[0]), 255);
    // Seed load + start together, seed load during run, reset mid-run
    do_reset();
    step(1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, peek_a());
    e = peek_a();
    step(1'b0, 1'b1, 8'h4B, 1'b1, e);
    chk("seed_in_run_ignored", int'(mm[0]), 0);
    step(1'b0, 1'b1, 8'h5A, 1'b1, peek_a());
    step(1'b0, 1'b0, 8'h00, 1'b1, peek_a());
    chk("seed_in_run_ignored2", int'(mm[0]), 0);
    do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hAB);
    chk("after_reset_first_AB", int'(mm[0]), 0);
    chk("after_reset_phase", int'(ph[0]), 1);
    // Random stream with restarts, seed loads, stalls and corruption
    for (int i = 0; i < 3000; i++) begin
      logic st, sl, v;
      logic [7:0] sd, p;
      st = ($urandom_range(0, 99) == 0);
      sl = ($urandom_range(0, 39) == 0);
      sd = 8'($urandom);
      v  = ($urandom_range(0, 9) < 7);
      p  = peek_a();
      if ($urandom_range(0, 9) == 0) p = p ^ 8'(1 << $urandom_range(0, 7));
      if (!m_run[0] && !m_run[1] && $urandom_range(0, 4) == 0) st = 1;
      step(st, sl, sd, v, p);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
